// File: rtl/rst_seq_pkg.sv
// Shared types and width helpers for the reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STRETCH = 2'd1,
    RELEASE = 2'd2,
    IDLE    = 2'd3
  } state_e;

  // Counter width large enough to hold the longer of the two programmable counts.
  function automatic int cnt_w(input int stretch_cycles, input int gap_cycles);
    int max_cnt;
    max_cnt = (stretch_cycles > gap_cycles) ? stretch_cycles : gap_cycles;
    return $clog2(max_cnt + 1);
  endfunction

  function automatic int ch_w(input int num_channels);
    return (num_channels > 1) ? $clog2(num_channels) : 1;
  endfunction

endpackage

// File: rtl/rst_sync_chain.sv
// Reset-removal synchroniser: cleared asynchronously, shifts in a constant 1.
module rst_sync_chain #(
  parameter int NUM_STAGES = 2
) (
  input  logic i_CLK,
  input  logic i_RST,
  output logic o_SYNC
);

  logic [NUM_STAGES-1:0] chain_q;

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[NUM_STAGES-2:0], 1'b1};
    end
  end

  assign o_SYNC = chain_q[NUM_STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// Reset sequencer: synchronised removal, stretch, then staggered per-channel release.
// Handshake: i_SW_RST_REQ is a level sampled only in IDLE; o_SW_RST_ACK pulses once when that sequence ends.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES     = 2,
  parameter int NUM_CHANNELS   = 4,
  parameter int STRETCH_CYCLES = 16,
  parameter int GAP_CYCLES     = 8
) (
  input  logic                    i_CLK,
  input  logic                    i_RST,
  input  logic                    i_SW_RST_REQ,
  output logic [NUM_CHANNELS-1:0] o_SYNC_RST_N,
  output logic                    o_SW_RST_ACK,
  output logic                    o_BUSY,
  output logic                    o_ALL_RELEASED,
  output state_e                  o_STATE
);

  localparam int CNT_W = cnt_w(STRETCH_CYCLES, GAP_CYCLES);
  localparam int CH_W  = ch_w(NUM_CHANNELS);

  localparam logic [CNT_W-1:0]        STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0]        GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CH_W-1:0]         CH_LAST      = CH_W'(NUM_CHANNELS - 1);
  localparam logic [NUM_CHANNELS-1:0] CH_ONE       = NUM_CHANNELS'(1);

  if (NUM_STAGES < 2 || NUM_CHANNELS < 1 || STRETCH_CYCLES < 1 || GAP_CYCLES < 1) begin : g_param_check
    $error("rst_sequencer: illegal parameter value");
  end

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CH_W-1:0]         idx_q, idx_d;
  logic [NUM_CHANNELS-1:0] rst_n_q, rst_n_d;
  logic                    all_rel_q, all_rel_d;
  logic                    ack_q, ack_d;
  logic                    sw_origin_q, sw_origin_d;
  logic                    sync_out;

  rst_sync_chain #(
    .NUM_STAGES(NUM_STAGES)
  ) u_sync (
    .i_CLK (i_CLK),
    .i_RST (i_RST),
    .o_SYNC(sync_out)
  );

  logic stretch_done, gap_done, last_ch, sw_start;
  assign stretch_done = (cnt_q == STRETCH_LAST);
  assign gap_done     = (cnt_q == GAP_LAST);
  assign last_ch      = (idx_q == CH_LAST);
  assign sw_start     = i_SW_RST_REQ;

  // State register plus all datapath registers share the asynchronous clear.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q     <= HOLD;
      cnt_q       <= '0;
      idx_q       <= '0;
      rst_n_q     <= '0;
      all_rel_q   <= 1'b0;
      ack_q       <= 1'b0;
      sw_origin_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      rst_n_q     <= rst_n_d;
      all_rel_q   <= all_rel_d;
      ack_q       <= ack_d;
      sw_origin_q <= sw_origin_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HOLD:    if (sync_out) state_d = STRETCH;
      STRETCH: if (stretch_done) state_d = (NUM_CHANNELS == 1) ? IDLE : RELEASE;
      RELEASE: if (gap_done && last_ch) state_d = IDLE;
      IDLE:    if (sw_start) state_d = STRETCH;
      default: state_d = HOLD;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    rst_n_d     = rst_n_q;
    all_rel_d   = all_rel_q;
    ack_d       = 1'b0;
    sw_origin_d = sw_origin_q;
    case (state_q)
      HOLD: begin
        if (sync_out) cnt_d = '0;
      end
      STRETCH: begin
        if (stretch_done) begin
          rst_n_d = rst_n_q | CH_ONE;
          cnt_d   = '0;
          idx_d   = CH_W'(1);
          if (NUM_CHANNELS == 1) begin
            all_rel_d   = 1'b1;
            ack_d       = sw_origin_q;
            sw_origin_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        if (gap_done) begin
          rst_n_d = rst_n_q | (CH_ONE << idx_q);
          cnt_d   = '0;
          idx_d   = idx_q + 1'b1;
          if (last_ch) begin
            all_rel_d   = 1'b1;
            ack_d       = sw_origin_q;
            sw_origin_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE: begin
        if (sw_start) begin
          rst_n_d     = '0;
          cnt_d       = '0;
          idx_d       = '0;
          all_rel_d   = 1'b0;
          sw_origin_d = 1'b1;
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    o_SYNC_RST_N   = rst_n_q;
    o_SW_RST_ACK   = ack_q;
    o_ALL_RELEASED = all_rel_q;
    o_BUSY         = (state_q != IDLE);
    o_STATE        = state_q;
  end

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer: default instance plus a minimal-parameter instance.
module tb_rst_sequencer;
  import rst_seq_pkg::*;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic req  = 1'b0;
  logic rst1 = 1'b1;
  logic req1 = 1'b0;

  logic [3:0] rst_n;
  logic       ack, busy, all_rel;
  state_e     st;
  logic [0:0] rst_n1;
  logic       ack1, busy1, all_rel1;
  state_e     st1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rst_sequencer u_dut (
    .i_CLK(clk), .i_RST(rst), .i_SW_RST_REQ(req),
    .o_SYNC_RST_N(rst_n), .o_SW_RST_ACK(ack), .o_BUSY(busy),
    .o_ALL_RELEASED(all_rel), .o_STATE(st)
  );

  rst_sequencer #(
    .NUM_STAGES(3), .NUM_CHANNELS(1), .STRETCH_CYCLES(1), .GAP_CYCLES(1)
  ) u_dut1 (
    .i_CLK(clk), .i_RST(rst1), .i_SW_RST_REQ(req1),
    .o_SYNC_RST_N(rst_n1), .o_SW_RST_ACK(ack1), .o_BUSY(busy1),
    .o_ALL_RELEASED(all_rel1), .o_STATE(st1)
  );

  // Observation vectors: {rst_n, all_released, busy, ack, state}
  function automatic logic [8:0] obs0();
    return {rst_n, all_rel, busy, ack, st};
  endfunction

  function automatic logic [5:0] obs1();
    return {rst_n1, all_rel1, busy1, ack1, st1};
  endfunction

  localparam logic [8:0] RST_VEC0 = {4'b0000, 1'b0, 1'b1, 1'b0, HOLD};
  localparam logic [5:0] RST_VEC1 = {1'b0, 1'b0, 1'b1, 1'b0, HOLD};

  // Expected default-instance outputs just after edge E(e) of a reset-started sequence.
  function automatic logic [8:0] exp_power(input int e);
    logic [3:0] m;
    state_e     s;
    m = '0;
    for (int i = 0; i < 4; i++) if (e >= 18 + 8 * i) m[i] = 1'b1;
    if (e < 2)       s = HOLD;
    else if (e < 18) s = STRETCH;
    else if (e < 42) s = RELEASE;
    else             s = IDLE;
    return {m, (e >= 42), (e < 42), 1'b0, s};
  endfunction

  // Expected default-instance outputs just after edge T+k of a software sequence.
  function automatic logic [8:0] exp_sw(input int k);
    logic [3:0] m;
    state_e     s;
    m = '0;
    for (int i = 0; i < 4; i++) if (k >= 16 + 8 * i) m[i] = 1'b1;
    if (k < 16)      s = STRETCH;
    else if (k < 40) s = RELEASE;
    else             s = IDLE;
    return {m, (k >= 40), (k < 40), (k == 40), s};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Releases i_RST and checks every edge E0..E44; req is held high over [req_from, req_to].
  task automatic run_timeline(input string name, input int req_from, input int req_to);
    logic [8:0] exp;
    rst = 1'b0;
    for (int e = 0; e < 45; e++) begin
      req = (e >= req_from && e <= req_to);
      tick();
      exp = exp_power(e);
      n_cmp++;
      if (obs0() !== exp) begin
        n_err++;
        $display("FAIL %s E%0d: got %b expected %b", name, e, obs0(), exp);
      end
    end
    req = 1'b0;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    rst1 = 1'b1;
    #1;
    n_cmp++;
    if (obs0() !== RST_VEC0) begin
      n_err++;
      $display("FAIL reset_values: got %b expected %b", obs0(), RST_VEC0);
    end
    n_cmp++;
    if (obs1() !== RST_VEC1) begin
      n_err++;
      $display("FAIL reset_values_p1: got %b expected %b", obs1(), RST_VEC1);
    end
  endtask

  task automatic test_power_on();
    rst = 1'b1;
    tick();
    run_timeline("power_on", -1, -1);
  endtask

  task automatic test_sw_reset();
    logic [8:0] exp;
    req = 1'b1;
    tick();
    req = 1'b0;
    exp = {4'b0000, 1'b0, 1'b1, 1'b0, STRETCH};
    n_cmp++;
    if (obs0() !== exp) begin
      n_err++;
      $display("FAIL sw_start: got %b expected %b", obs0(), exp);
    end
    for (int k = 1; k < 45; k++) begin
      tick();
      exp = exp_sw(k);
      n_cmp++;
      if (obs0() !== exp) begin
        n_err++;
        $display("FAIL sw_reset T+%0d: got %b expected %b", k, obs0(), exp);
      end
    end
  endtask

  task automatic test_req_while_busy();
    rst = 1'b1;
    tick();
    run_timeline("req_busy", 19, 25);
  endtask

  task automatic test_mid_reset();
    logic [8:0] exp;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int e = 0; e <= 30; e++) tick();
    exp = exp_power(30);
    n_cmp++;
    if (obs0() !== exp) begin
      n_err++;
      $display("FAIL mid_rst_before E30: got %b expected %b", obs0(), exp);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (obs0() !== RST_VEC0) begin
      n_err++;
      $display("FAIL mid_rst_async: got %b expected %b", obs0(), RST_VEC0);
    end
    tick();
    tick();
    run_timeline("mid_rst_restart", -1, -1);
  endtask

  task automatic test_sw_abort();
    req = 1'b1;
    tick();
    req = 1'b0;
    for (int k = 1; k <= 20; k++) tick();
    rst = 1'b1;
    #1;
    n_cmp++;
    if (obs0() !== RST_VEC0) begin
      n_err++;
      $display("FAIL sw_abort_async: got %b expected %b", obs0(), RST_VEC0);
    end
    tick();
    run_timeline("after_sw_abort", -1, -1);
  endtask

  task automatic test_short_pulse();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (obs0() !== RST_VEC0) begin
      n_err++;
      $display("FAIL short_pulse_clear: got %b expected %b", obs0(), RST_VEC0);
    end
    #2;
    run_timeline("short_pulse", -1, -1);
  endtask

  task automatic test_param_sweep();
    logic [5:0] exp;
    rst1 = 1'b1;
    #1;
    rst1 = 1'b0;
    for (int e = 0; e <= 4; e++) begin
      tick();
      if (e < 3)       exp = {1'b0, 1'b0, 1'b1, 1'b0, HOLD};
      else if (e == 3) exp = {1'b0, 1'b0, 1'b1, 1'b0, STRETCH};
      else             exp = {1'b1, 1'b1, 1'b0, 1'b0, IDLE};
      n_cmp++;
      if (obs1() !== exp) begin
        n_err++;
        $display("FAIL sweep_power E%0d: got %b expected %b", e, obs1(), exp);
      end
    end
    req1 = 1'b1;
    for (int k = 5; k <= 12; k++) begin
      tick();
      if (k % 2 == 1) exp = {1'b0, 1'b0, 1'b1, 1'b0, STRETCH};
      else            exp = {1'b1, 1'b1, 1'b0, 1'b1, IDLE};
      n_cmp++;
      if (obs1() !== exp) begin
        n_err++;
        $display("FAIL sweep_held_req E%0d: got %b expected %b", k, obs1(), exp);
      end
    end
    req1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_sw_reset();
    test_req_while_busy();
    test_mid_reset();
    test_sw_abort();
    test_short_pulse();
    test_param_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rst_sequencer.md
# rst_sequencer

Parametrised reset sequencer for a single clock domain. It asserts a bank of NUM_CHANNELS active-low synchronous resets immediately when the asynchronous system reset is applied. It synchronises reset removal through a NUM_STAGES flop chain and stretches it by a programmable count. It then releases the channels one at a time, in index order, with a fixed gap between them. Control logic can also start a full reset sequence in-band through a request/acknowledge handshake. The block sits between the top-level reset pin and each clock domain's consumers, e.g. register file, FIFOs and UART.

## Interface
- NUM_STAGES, 2: synchroniser depth. Must be ≥2.
- NUM_CHANNELS, 4: number of reset outputs. Must be ≥1.
- STRETCH_CYCLES, 16: cycles that all outputs stay asserted after synchronised release. Must be ≥1.
- GAP_CYCLES, 8: cycles between release of consecutive channels. Must be ≥1.
---
- i_CLK  in  1  clock.
- i_RST  in  1  reset; asynchronous, active-high.
- i_SW_RST_REQ  in  1  software reset request. Level, synchronous to i_CLK, sampled only in IDLE.
- o_SYNC_RST_N  out  NUM_CHANNELS  per-channel reset. Active-low, deasserts synchronously.
- o_SW_RST_ACK  out  1  one-cycle pulse when a software-initiated sequence completes.
- o_BUSY  out  1  high in every state except IDLE.
- o_ALL_RELEASED  out  1  high when every channel is released.

## Operation
- Reset values while i_RST=1:
  - o_SYNC_RST_N=0 (all bits).
  - o_BUSY=1, o_ALL_RELEASED=0, o_SW_RST_ACK=0.
  - Synchroniser chain cleared to 0, state HOLD, counters 0.
- States:
  - HOLD: waits for the synchroniser output to go to 1, then goes to STRETCH with the counter at 0.
  - STRETCH: counts STRETCH_CYCLES cycles. On the last one it releases channel 0 and goes to RELEASE with channel index 1. If NUM_CHANNELS=1 it goes straight to IDLE instead.
  - RELEASE: counts GAP_CYCLES cycles per channel, then releases channel idx. When the last channel is released it goes to IDLE.
  - IDLE: if i_SW_RST_REQ=1, drives all o_SYNC_RST_N bits to 0, sets the sw_origin flag and goes to STRETCH.
- Each released channel stays released until the next i_RST or software request.
- o_ALL_RELEASED is registered and rises on the same edge as the last channel release.
- o_SW_RST_ACK pulses on that same edge only when sw_origin=1; sw_origin then clears. Sequences started by i_RST never generate an ACK.
- Counter width is $clog2(max(STRETCH_CYCLES, GAP_CYCLES)+1). Counters are unsigned, compare for equality, and never wrap.
- Boundary behaviour:
  - i_RST asserted mid-sequence, including during a software sequence: every output returns to its reset value immediately and asynchronously, and no ACK is produced.
  - i_SW_RST_REQ outside IDLE is ignored; nothing is queued.
  - A request held high continuously restarts a new sequence on the edge after the ACK.
  - i_RST pulse shorter than one clock period: still clears all outputs and runs a full sequence.

## Timing
- Let E0 be the first rising edge after i_RST falls.
- The synchroniser output is 1 after edge E(NUM_STAGES-1); the FSM enters STRETCH at E(NUM_STAGES).
- Channel i is released at edge E(NUM_STAGES + STRETCH_CYCLES + i·GAP_CYCLES).
- With defaults, channels 0..3 are released at E18, E26, E34, E42, and o_ALL_RELEASED rises at E42.
- Software request sampled high in IDLE at edge T:
  - o_SYNC_RST_N=0 and o_BUSY=1 after T.
  - Channel i is released at T + STRETCH_CYCLES + i·GAP_CYCLES.
  - o_SW_RST_ACK is high for exactly the cycle following the last release edge.
- Reset assertion is combinational-free: every output flop is asynchronously cleared by i_RST.

## Structure
- Package rst_seq_pkg holds:
  - state enum {HOLD, STRETCH, RELEASE, IDLE}, 2 bits;
  - a CNT_W width helper (clog2 of the max count);
  - a CH_W helper for the channel index.
- Sub-module rst_sync_chain holds the NUM_STAGES flop chain. It is asynchronously cleared to 0 by active-high i_RST, shifts in a constant 1, and outputs the last stage.
- The FSM, counters and output registers live in rst_sequencer.

## Test plan
- Power-on with defaults: deassert i_RST at time t → o_SYNC_RST_N goes 0001 at E18, 0011 at E26, 0111 at E34, 1111 at E42. o_ALL_RELEASED=1 at E42, o_SW_RST_ACK never pulses.
- Software reset in IDLE: pulse i_SW_RST_REQ at T → o_SYNC_RST_N=0000 after T, 1111 at T+40. o_SW_RST_ACK is high for one cycle after T+40, and o_BUSY falls at T+40.
- Request while busy: assert i_SW_RST_REQ at E20 during power-on → release timeline unchanged (E26, E34, E42), and no ACK.
- Mid-sequence i_RST: assert at E30 (channels 0 and 1 released) → all outputs go 0 asynchronously before the next edge, o_BUSY=1. After deassert the full timeline restarts from the new E0.
- Parameter sweep NUM_CHANNELS=1, STRETCH_CYCLES=1, GAP_CYCLES=1, NUM_STAGES=3 → the single channel is released at E4. A held request retriggers a sequence every 2 cycles, each ending in one ACK pulse.
